// File: rtl/maze_draw_pipe_if.sv
// Pixel/level/ROM/sprite bus for maze_draw_pipe.
// master: the timing generator, level lookup, image ROM and sprite logic.
//   It drives pix_en, curr_x/curr_y, the geometry inputs, walls, rom_data
//   and the sprite vectors, and it receives maze_col/maze_row, rom_addr
//   and draw_r/g/b/draw_valid.
// slave: the draw pipeline. It has the opposite directions.
interface maze_draw_pipe_if #(
  parameter int NUM_SPRITES = 4
);
  logic                       pix_en;
  logic [10:0]                curr_x;
  logic [10:0]                curr_y;
  logic [9:0]                 tile_w;
  logic [9:0]                 tile_h;
  logic [9:0]                 wall_margin;
  logic [4:0]                 num_cols;
  logic [4:0]                 num_rows;
  logic [4:0]                 maze_col;
  logic [4:0]                 maze_row;
  logic [3:0]                 walls;
  logic [12:0]                rom_addr;
  logic [11:0]                rom_data;
  logic [11*NUM_SPRITES-1:0]  spr_x;
  logic [11*NUM_SPRITES-1:0]  spr_y;
  logic [12*NUM_SPRITES-1:0]  spr_rgb;
  logic [NUM_SPRITES-1:0]     spr_en;
  logic [3:0]                 draw_r;
  logic [3:0]                 draw_g;
  logic [3:0]                 draw_b;
  logic                       draw_valid;

  modport master (
    output pix_en, curr_x, curr_y, tile_w, tile_h, wall_margin, num_cols, num_rows,
           walls, rom_data, spr_x, spr_y, spr_rgb, spr_en,
    input  maze_col, maze_row, rom_addr, draw_r, draw_g, draw_b, draw_valid
  );

  modport slave (
    input  pix_en, curr_x, curr_y, tile_w, tile_h, wall_margin, num_cols, num_rows,
           walls, rom_data, spr_x, spr_y, spr_rgb, spr_en,
    output maze_col, maze_row, rom_addr, draw_r, draw_g, draw_b, draw_valid
  );
endinterface

// File: rtl/maze_draw_pipe.sv
// Three-stage pixel colour pipeline for the maze game.
// The priority order is image overlay, then sprites (index 0 first), then
// maze walls, then background. Tile position is tracked with incremental
// counters. Level geometry is latched at the frame-start pixel.
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   bus        maze_draw_pipe_if.slave carrying:
//              pixel coordinates and pix_en;
//              geometry inputs;
//              maze_col/maze_row out and walls back;
//              rom_addr out and rom_data back;
//              sprite vectors;
//              the registered colour and draw_valid.
module maze_draw_pipe #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_SIZE    = 10,
  parameter int          MAZE_Y0     = 100,
  parameter int          ID_X0       = 1350,
  parameter int          ID_Y0       = 120,
  parameter int          ID_W        = 128,
  parameter int          ID_H        = 64,
  parameter logic [11:0] BG_RGB      = 12'h00F,
  parameter logic [11:0] WALL_RGB    = 12'hF00
) (
  input logic             clk,
  input logic             rst,
  maze_draw_pipe_if.slave bus
);

  localparam int          IDX_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [10:0] MAZE_Y0_L = 11'(MAZE_Y0);
  localparam logic [11:0] ID_X_LO   = 12'(ID_X0);
  localparam logic [11:0] ID_X_HI   = 12'(ID_X0 + ID_W);
  localparam logic [11:0] ID_Y_LO   = 12'(ID_Y0);
  localparam logic [11:0] ID_Y_HI   = 12'(ID_Y0 + ID_H);
  localparam logic [12:0] ID_X0_A   = 13'(ID_X0);
  localparam logic [12:0] ID_Y0_A   = 13'(ID_Y0);
  localparam logic [12:0] ID_W_A    = 13'(ID_W);
  localparam logic [11:0] SPR_SZ    = 12'(SPR_SIZE);

  logic [9:0]  geo_tw, geo_th, geo_m;
  logic [4:0]  geo_cols, geo_rows;
  logic        frame_start;
  logic [9:0]  eff_tw, eff_th;
  logic [11:0] x12, y12;
  logic        img_hit;
  logic [12:0] img_addr;
  logic        spr_hit;
  logic [IDX_W-1:0] spr_idx;
  logic [11:0] sx, sy;

  logic        v1, in_maze, img_hit1, spr_hit1;
  logic [9:0]  xt, yt;
  logic [4:0]  col_q, row_q;
  logic [12:0] rom_addr_q;
  logic [IDX_W-1:0] spr_idx1;
  logic [12*NUM_SPRITES-1:0] spr_rgb1;

  logic        wall_hit;
  logic [11:0] spr_sel;
  logic        v2, img_hit2, spr_hit2, wall_hit2;
  logic [11:0] rom_data2, spr_col2;

  logic        v3;
  logic [11:0] colour_q;

  // A zero tile size is treated as 1. The frame-start pixel already uses
  // the incoming geometry, so a level switch lines up with the frame.
  always_comb begin
    frame_start = bus.pix_en && (bus.curr_x == 11'd0) && (bus.curr_y == 11'd0);
    eff_tw      = geo_tw;
    eff_th      = geo_th;
    if (frame_start) begin
      eff_tw = (bus.tile_w == 10'd0) ? 10'd1 : bus.tile_w;
      eff_th = (bus.tile_h == 10'd0) ? 10'd1 : bus.tile_h;
    end
  end

  // The hit tests use 12-bit compares so that a sprite near x = 2047
  // cannot wrap around onto the left edge.
  assign x12      = {1'b0, bus.curr_x};
  assign y12      = {1'b0, bus.curr_y};
  assign img_hit  = (x12 >= ID_X_LO) && (x12 < ID_X_HI) && (y12 >= ID_Y_LO) && (y12 < ID_Y_HI);
  assign img_addr = ({2'b00, bus.curr_y} - ID_Y0_A) * ID_W_A + ({2'b00, bus.curr_x} - ID_X0_A);

  // The loop scans downward, so the lowest hitting index is the last write.
  always_comb begin
    spr_hit = 1'b0;
    spr_idx = '0;
    sx      = '0;
    sy      = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      sx = {1'b0, bus.spr_x[11*i +: 11]};
      sy = {1'b0, bus.spr_y[11*i +: 11]};
      if (bus.spr_en[i] && (x12 >= sx) && (x12 < sx + SPR_SZ) &&
          (y12 >= sy) && (y12 < sy + SPR_SZ)) begin
        spr_hit = 1'b1;
        spr_idx = IDX_W'(i);
      end
    end
  end

  // Stage 1 holds the geometry latch and the tile counters. All state here
  // freezes while pix_en is low. The y counter only moves on column 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      geo_tw     <= 10'd1;
      geo_th     <= 10'd1;
      geo_m      <= 10'd0;
      geo_cols   <= 5'd0;
      geo_rows   <= 5'd0;
      v1         <= 1'b0;
      xt         <= 10'd0;
      yt         <= 10'd0;
      col_q      <= 5'd0;
      row_q      <= 5'd0;
      in_maze    <= 1'b0;
      rom_addr_q <= 13'd0;
      img_hit1   <= 1'b0;
      spr_hit1   <= 1'b0;
      spr_idx1   <= '0;
      spr_rgb1   <= '0;
    end else begin
      v1 <= bus.pix_en;
      if (bus.pix_en) begin
        if (frame_start) begin
          geo_tw   <= eff_tw;
          geo_th   <= eff_th;
          geo_m    <= bus.wall_margin;
          geo_cols <= bus.num_cols;
          geo_rows <= bus.num_rows;
        end
        if (bus.curr_x == 11'd0) begin
          xt    <= 10'd0;
          col_q <= 5'd0;
          if (bus.curr_y < MAZE_Y0_L) begin
            in_maze <= 1'b0;
          end else if (bus.curr_y == MAZE_Y0_L) begin
            yt      <= 10'd0;
            row_q   <= 5'd0;
            in_maze <= 1'b1;
          end else if (yt >= eff_th - 10'd1) begin
            yt <= 10'd0;
            if (row_q != 5'd31) row_q <= row_q + 5'd1;
          end else begin
            yt <= yt + 10'd1;
          end
        end else if (xt >= eff_tw - 10'd1) begin
          xt <= 10'd0;
          if (col_q != 5'd31) col_q <= col_q + 5'd1;
        end else begin
          xt <= xt + 10'd1;
        end
        if (img_hit) rom_addr_q <= img_addr;
        img_hit1 <= img_hit;
        spr_hit1 <= spr_hit;
        spr_idx1 <= spr_idx;
        spr_rgb1 <= bus.spr_rgb;
      end
    end
  end

  assign bus.maze_col = col_q;
  assign bus.maze_row = row_q;
  assign bus.rom_addr = rom_addr_q;

  // The bottom and right tests are written as xt + m >= size. This stays
  // correct without underflow when the margin is larger than the tile.
  always_comb begin
    wall_hit = in_maze && (col_q < geo_cols) && (row_q < geo_rows) &&
               ((bus.walls[3] && (yt < geo_m)) ||
                (bus.walls[2] && ({1'b0, yt} + {1'b0, geo_m} >= {1'b0, geo_th})) ||
                (bus.walls[1] && (xt < geo_m)) ||
                (bus.walls[0] && ({1'b0, xt} + {1'b0, geo_m} >= {1'b0, geo_tw})));
    spr_sel = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (spr_idx1 == IDX_W'(i)) spr_sel = spr_rgb1[12*i +: 12];
    end
  end

  // Stages 2 and 3 shift every cycle. When pix_en was low they carry a
  // bubble, and the colour register keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      img_hit2  <= 1'b0;
      spr_hit2  <= 1'b0;
      wall_hit2 <= 1'b0;
      rom_data2 <= 12'd0;
      spr_col2  <= 12'd0;
      v3        <= 1'b0;
      colour_q  <= BG_RGB;
    end else begin
      v2        <= v1;
      img_hit2  <= img_hit1;
      spr_hit2  <= spr_hit1;
      wall_hit2 <= wall_hit;
      rom_data2 <= bus.rom_data;
      spr_col2  <= spr_sel;
      v3        <= v2;
      if (v2) begin
        if (img_hit2)       colour_q <= rom_data2;
        else if (spr_hit2)  colour_q <= spr_col2;
        else if (wall_hit2) colour_q <= WALL_RGB;
        else                colour_q <= BG_RGB;
      end
    end
  end

  assign bus.draw_r     = colour_q[11:8];
  assign bus.draw_g     = colour_q[7:4];
  assign bus.draw_b     = colour_q[3:0];
  assign bus.draw_valid = v3;

endmodule

// File: tb/tb_maze_draw_pipe.sv
// Testbench for maze_draw_pipe.
// A reference model computes each pixel colour from tile indices, which
// are found by division and modulo on the pixel coordinates. The bench
// keeps a 3-deep queue of expected outputs and checks them against the
// delayed pipeline output.
module tb_maze_draw_pipe;
  localparam int NS = 4;

  typedef struct {
    bit          v;
    logic [11:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_draw_pipe_if #(.NUM_SPRITES(NS)) bus ();
  maze_draw_pipe #(.NUM_SPRITES(NS)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0] wall_tab [0:31][0:31];

  function automatic logic [11:0] rom_fn(input logic [12:0] a);
    logic [15:0] t;
    t = {3'b000, a} * 16'd7 + 16'h0155;
    return t[11:0];
  endfunction

  assign bus.walls    = wall_tab[bus.maze_row][bus.maze_col];
  assign bus.rom_data = rom_fn(bus.rom_addr);

  int          checks = 0;
  int          errors = 0;
  int          gap_pct = 0;
  int          m_tw, m_th, m_m, m_cols, m_rows, last_addr;
  bit          m_framed;
  logic [11:0] cur_col;
  pix_t        pipe_q[$];
  int          sx[NS], sy[NS];
  logic [11:0] srgb[NS];
  bit          sen[NS];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input logic [11:0] rgb, input bit en);
    sx[i] = x; sy[i] = y; srgb[i] = rgb; sen[i] = en;
    bus.spr_x[11*i +: 11]   = 11'(x);
    bus.spr_y[11*i +: 11]   = 11'(y);
    bus.spr_rgb[12*i +: 12] = rgb;
    bus.spr_en[i]           = en;
  endtask

  function automatic bit img_in(input int x, input int y);
    return (x >= 1350) && (x < 1478) && (y >= 120) && (y < 184);
  endfunction

  function automatic logic [11:0] model_colour(input int x, input int y);
    int col, row, xt, yt;
    logic [3:0] w;
    if (img_in(x, y)) return rom_fn(13'((y - 120) * 128 + (x - 1350)));
    for (int i = 0; i < NS; i++)
      if (sen[i] && x >= sx[i] && x < sx[i] + 10 && y >= sy[i] && y < sy[i] + 10) return srgb[i];
    if (m_framed && y >= 100) begin
      col = x / m_tw; if (col > 31) col = 31;
      xt  = x % m_tw;
      row = (y - 100) / m_th; if (row > 31) row = 31;
      yt  = (y - 100) % m_th;
      if (col < m_cols && row < m_rows) begin
        w = wall_tab[row][col];
        if ((w[3] && yt < m_m) || (w[2] && yt >= m_th - m_m) ||
            (w[1] && xt < m_m) || (w[0] && xt >= m_tw - m_m)) return 12'hF00;
      end
    end
    return 12'h00F;
  endfunction

  task automatic apply_stimulus(input bit en, input int x, input int y);
    pix_t p;
    int   col, row;
    bus.pix_en = en;
    bus.curr_x = 11'(x);
    bus.curr_y = 11'(y);
    p.v = en;
    p.c = 12'h000;
    if (en) begin
      if (x == 0 && y == 0) begin
        m_tw     = (bus.tile_w == 10'd0) ? 1 : int'(bus.tile_w);
        m_th     = (bus.tile_h == 10'd0) ? 1 : int'(bus.tile_h);
        m_m      = int'(bus.wall_margin);
        m_cols   = int'(bus.num_cols);
        m_rows   = int'(bus.num_rows);
        m_framed = 1'b1;
      end
      p.c = model_colour(x, y);
      if (img_in(x, y)) last_addr = (y - 120) * 128 + (x - 1350);
    end
    pipe_q.push_back(p);
    @(posedge clk);
    #1;
    if (pipe_q.size() == 3) begin
      p = pipe_q.pop_front();
      check_output("draw_valid", 32'(bus.draw_valid), 32'(p.v));
      if (p.v) cur_col = p.c;
      check_output(p.v ? "draw_rgb" : "draw_hold",
                   32'({bus.draw_r, bus.draw_g, bus.draw_b}), 32'(cur_col));
    end
    if (en) begin
      check_output("rom_addr", 32'(bus.rom_addr), 32'(last_addr));
      if (m_framed) begin
        col = x / m_tw; if (col > 31) col = 31;
        check_output("maze_col", 32'(bus.maze_col), 32'(col));
        if (y >= 100) begin
          row = (y - 100) / m_th; if (row > 31) row = 31;
          check_output("maze_row", 32'(bus.maze_row), 32'(row));
        end
      end
    end
  endtask

  task automatic scan_line(input int y, input int x_last);
    for (int x = 0; x <= x_last; x++) begin
      if (int'($urandom_range(99)) < gap_pct)
        apply_stimulus(1'b0, int'($urandom_range(2047)), int'($urandom_range(2047)));
      apply_stimulus(1'b1, x, y);
    end
  endtask

  task automatic scan_lines(input int y0, input int y1, input int x_last);
    for (int y = y0; y <= y1; y++) scan_line(y, x_last);
  endtask

  task automatic flush();
    repeat (3) apply_stimulus(1'b0, int'($urandom_range(2047)), int'($urandom_range(2047)));
  endtask

  task automatic fill_walls(input logic [3:0] w);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) wall_tab[r][c] = w;
  endtask

  task automatic do_reset(input int cycles);
    pix_t p;
    rst = 1'b1;
    bus.pix_en = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_output("rst_valid", 32'(bus.draw_valid), 32'd0);
    check_output("rst_rgb", 32'({bus.draw_r, bus.draw_g, bus.draw_b}), 32'h00F);
    check_output("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_output("rst_maze_col", 32'(bus.maze_col), 32'd0);
    check_output("rst_maze_row", 32'(bus.maze_row), 32'd0);
    rst = 1'b0;
    pipe_q.delete();
    p.v = 1'b0;
    p.c = 12'h000;
    pipe_q.push_back(p);
    pipe_q.push_back(p);
    cur_col   = 12'h00F;
    last_addr = 0;
    m_framed  = 1'b0;
    m_tw = 1; m_th = 1; m_m = 0; m_cols = 0; m_rows = 0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.pix_en      = 1'b0;
    bus.curr_x      = 11'd0;
    bus.curr_y      = 11'd0;
    bus.tile_w      = 10'd40;
    bus.tile_h      = 10'd40;
    bus.wall_margin = 10'd4;
    bus.num_cols    = 5'd2;
    bus.num_rows    = 5'd2;
    fill_walls(4'b1000);
    for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 12'h000, 1'b0);
    do_reset(2);

    $display("[TB] frame A: top walls, latency and reset colour");
    scan_line(0, 4);
    scan_lines(1, 99, 0);
    gap_pct = 20;
    scan_line(100, 120);
    scan_lines(101, 103, 90);
    scan_line(104, 100);
    flush();
    fill_walls(4'b0001);
    scan_lines(105, 109, 0);
    scan_line(110, 100);
    scan_lines(111, 149, 0);
    bus.tile_w = 10'd20;
    scan_line(150, 100);
    scan_lines(151, 199, 0);

    $display("[TB] sprites: priority, enable, right-edge no-wrap");
    set_sprite(0, 200, 200, 12'h0F0, 1'b1);
    set_sprite(1, 200, 200, 12'hFF0, 1'b1);
    set_sprite(2, 2040, 200, 12'h0FF, 1'b1);
    scan_lines(200, 204, 0);
    scan_line(205, 210);
    set_sprite(0, 200, 200, 12'h0F0, 1'b0);
    scan_line(206, 210);
    scan_lines(207, 209, 0);

    $display("[TB] frame B: new tile width, image overlay, reset mid-image");
    set_sprite(3, 1470, 178, 12'hF0F, 1'b1);
    scan_line(0, 0);
    scan_lines(1, 99, 0);
    scan_line(100, 60);
    scan_lines(101, 119, 0);
    scan_line(120, 1360);
    scan_lines(121, 181, 0);
    scan_line(182, 1400);
    do_reset(1);
    scan_line(183, 1480);

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      flush();
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++) wall_tab[r][c] = 4'($urandom);
      for (int i = 0; i < NS; i++)
        set_sprite(i, int'($urandom_range(160)), int'($urandom_range(140, 95)),
                   12'($urandom), 1'($urandom));
      bus.tile_w      = (f == 0) ? 10'd0 : 10'($urandom_range(30, 1));
      bus.tile_h      = (f == 0) ? 10'd0 : 10'($urandom_range(20, 1));
      bus.wall_margin = (f == 1) ? bus.tile_w + 10'd5 : 10'($urandom_range(8));
      bus.num_cols    = 5'($urandom_range(31));
      bus.num_rows    = 5'($urandom_range(31, 1));
      scan_line(0, 5);
      scan_lines(1, 99, 0);
      scan_lines(100, 135, 150);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_draw_pipe.md
Name: maze_draw_pipe

Overview:
- Pipelined, parametrised successor to the maze pixel colour generator. Sits between the VGA timing counters and the RGB output registers.
- Produces the 12-bit colour for each scanned pixel from four sources, in priority order: ID image overlay, N player/enemy sprites, maze walls, background.
- Uses per-pixel incremental tile counters instead of dividers. Level geometry comes in at runtime and is latched once per frame, so a level switch never tears mid-frame.
- Fixed 3-cycle latency from pixel coordinate to colour.

Parameters:
- NUM_SPRITES, 4, number of square sprites (1..8); index 0 has highest priority.
- SPR_SIZE, 10, sprite edge length in pixels.
- MAZE_Y0, 100, first maze scanline.
- ID_X0, 1350, image overlay left edge.
- ID_Y0, 120, image overlay top edge.
- ID_W, 128, image width (power of 2).
- ID_H, 64, image height.
- BG_RGB, 12'h00F, background colour.
- WALL_RGB, 12'hF00, wall colour.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  curr_x/curr_y valid this cycle; advances one pixel per asserted cycle
- curr_x  in  11  scan x
- curr_y  in  11  scan y
- tile_w  in  10  level tile width (sampled at frame start)
- tile_h  in  10  level tile height (sampled at frame start)
- wall_margin  in  10  wall thickness (sampled at frame start)
- num_cols  in  5  maze columns (sampled at frame start)
- num_rows  in  5  maze rows (sampled at frame start)
- maze_col  out  5  tile column to the external level lookup (registered)
- maze_row  out  5  tile row to the external level lookup (registered)
- walls  in  4  {top,bottom,left,right}; valid one cycle after maze_col/maze_row
- rom_addr  out  13  image ROM address (registered)
- rom_data  in  12  image ROM data; 1-cycle synchronous read
- spr_x  in  11*NUM_SPRITES  packed sprite x positions
- spr_y  in  11*NUM_SPRITES  packed sprite y positions
- spr_rgb  in  12*NUM_SPRITES  packed sprite colours
- spr_en  in  NUM_SPRITES  per-sprite enable
- draw_r  out  4  red (registered)
- draw_g  out  4  green (registered)
- draw_b  out  4  blue (registered)
- draw_valid  out  1  pix_en delayed 3 cycles

Behaviour:
- Reset (rst high at a clk edge):
  - All pipeline registers, tile counters, maze_col, maze_row, rom_addr and draw_valid clear to 0.
  - draw_r/g/b = BG_RGB.
  - Latched geometry resets to tile_w = tile_h = 1, margin 0, rows = cols = 0, so no walls are drawn until the first frame start.
  - Reset mid-frame drops every in-flight pixel; draw_valid stays 0 for 3 cycles after rst deasserts.
- Frame start = pix_en && curr_x == 0 && curr_y == 0.
  - Latch the geometry inputs on this cycle.
  - A value of 0 in tile_w or tile_h latches as 1.
  - If wall_margin > tile dimension, walls fill the whole tile (no wrap).
  - The latched values take effect from this same pixel onward.
- Stage 1 (S1), cycle after pix_en; all state holds while pix_en is low.
  - x tile counter:
    - curr_x == 0 → xt = 0, col = 0.
    - Otherwise xt + 1; when xt reaches tile_w − 1 it wraps to 0 and col increments.
    - col saturates at 31.
  - y tile counter, updated only on pixels with curr_x == 0:
    - curr_y < MAZE_Y0 → in_maze = 0.
    - curr_y == MAZE_Y0 → yt = 0, row = 0, in_maze = 1.
    - Otherwise yt + 1, wrapping at tile_h − 1 with row + 1; row saturates at 31.
  - Register maze_col, maze_row, xt, yt, in_maze.
  - Image hit: ID_X0 ≤ x < ID_X0 + ID_W and ID_Y0 ≤ y < ID_Y0 + ID_H.
    - On a hit, rom_addr = (y − ID_Y0) * ID_W + (x − ID_X0), truncated to 13 bits.
    - On a miss, rom_addr holds its previous value.
  - Sprite hit i: spr_en[i] && spr_x_i ≤ x < spr_x_i + SPR_SIZE, and the same test in y.
    - Compare in 12 bits so a sprite at x = 2040 does not wrap.
    - Encode the lowest hit index; register hit flag and index.
- Stage 2 (S2): register walls and rom_data with the S1 side data.
  - Wall hit = in_maze && col < cols && row < rows && any of:
    - top && yt < m
    - bottom && yt ≥ tile_h − m
    - left && xt < m
    - right && xt ≥ tile_w − m
- Stage 3 (S3) colour select, registered:
  - image hit → rom_data
  - else sprite hit → spr_rgb[idx] (sprite inputs sampled in S1)
  - else wall hit → WALL_RGB
  - else BG_RGB
- When pix_en is low, the pipeline shifts a bubble and draw_valid = 0. The colour registers hold their last value.

Test Plan:
- Reset, then drive pix_en for 5 cycles → draw_valid first high exactly 3 cycles after the first pix_en, and draw = BG 0/0/F before that.
- Geometry tile_w = 40, tile_h = 40, m = 4, cols = 2, rows = 2; walls stub returns 4'b1000 for all tiles; scan line y = 100 → red F/0/0 for x = 0..79, blue from x = 80. Then line y = 104 → all blue.
- Same geometry, walls = 4'b0001, line y = 110 → red at x = 36..39 and 76..79 only. maze_col reads 1 at the cycle after x = 40 is presented.
- Change tile_w from 40 to 20 mid-frame at y = 300 → rest of the frame still uses 40. The next frame uses 20 (red at x = 16..19 with walls = 0001).
- Sprites 0 and 1 both at (200,200) with colours 0F0 and FF0 → pixel (205,205) = 0/F/0. Clear spr_en[0] → 0xFF0. Sprite at (2040,5) → no hit at x = 0.
- Pixel (1350,120) → rom_addr 0. Pixel (1477,183) → rom_addr 8191. Output equals rom_data even when overlapping a sprite; rst asserted mid-image → draw_valid 0 for 3 cycles.
